// File: rtl/remote_update_pkg.sv
// Shared codes for the remote-update Avalon-MM programming master: parameter/source
// codes, error codes, FSM states and the fixed step table.
package remote_update_pkg;

  localparam int unsigned PageW   = 22;
  localparam int unsigned WdW     = 12;
  localparam int unsigned StatusW = 29;
  localparam int unsigned StepW   = 3;

  // Remote-update parameter codes (av_address[2:0])
  localparam logic [2:0] ParamReconfigSrc = 3'b000;
  localparam logic [2:0] ParamWdValue     = 3'b010;
  localparam logic [2:0] ParamWdEn        = 3'b011;
  localparam logic [2:0] ParamPage        = 3'b100;

  // Source codes (av_address[5:4])
  localparam logic [1:0] SrcCurrent  = 2'b00;
  localparam logic [1:0] SrcReconfig = 2'b01;

  localparam logic [StepW-1:0] StepLastWrite = 3'd2;
  localparam logic [StepW-1:0] StepLast      = 3'd6;

  typedef enum logic [1:0] {
    ErrOk       = 2'd0,
    ErrMismatch = 2'd1,
    ErrTimeout  = 2'd2
  } err_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StCheck,
    StFinish
  } state_e;

  typedef struct packed {
    logic       is_read;
    logic [1:0] src;
    logic [2:0] param;
  } step_op_t;

  // Fixed operation sequence: three writes, three read-backs, then the reconfig source.
  function automatic step_op_t step_op(logic [StepW-1:0] step);
    step_op_t op;
    op = '{1'b0, SrcCurrent, ParamPage};
    case (step)
      3'd0:    op = '{1'b0, SrcCurrent, ParamPage};
      3'd1:    op = '{1'b0, SrcCurrent, ParamWdValue};
      3'd2:    op = '{1'b0, SrcCurrent, ParamWdEn};
      3'd3:    op = '{1'b1, SrcCurrent, ParamPage};
      3'd4:    op = '{1'b1, SrcCurrent, ParamWdValue};
      3'd5:    op = '{1'b1, SrcCurrent, ParamWdEn};
      3'd6:    op = '{1'b1, SrcReconfig, ParamReconfigSrc};
      default: op = '{1'b0, SrcCurrent, ParamPage};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/remote_update_avalon_master.sv
// Avalon-MM master that programs the remote-update boot page and watchdog, optionally
// reads each field back, then reads the reconfiguration source.
module remote_update_avalon_master
  import remote_update_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 255,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_start,
  input  logic [PageW-1:0]   cmd_page_addr,
  input  logic [WdW-1:0]     cmd_wd_value,
  input  logic               cmd_wd_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         error,
  output logic [StatusW-1:0] status_src,
  output logic [5:0]         av_address,
  output logic               av_write,
  output logic               av_read,
  output logic [31:0]        av_writedata,
  input  logic               av_waitrequest,
  input  logic [31:0]        av_readdata,
  input  logic               av_readdatavalid
);

  localparam int unsigned CntW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RD_TIMEOUT - 1);

  state_e             state_q;
  logic [StepW-1:0]   step_q;
  logic [PageW-1:0]   page_q;
  logic [WdW-1:0]     wd_q;
  logic               en_q;
  logic [StatusW-1:0] rdata_q;
  logic [CntW-1:0]    cnt_q;

  step_op_t           op;
  logic [31:0]        wdata;
  logic               mismatch;
  logic [StepW-1:0]   step_after_write;
  logic               unused_rdata_hi;

  assign unused_rdata_hi = ^av_readdata[31:StatusW];

  always_comb begin
    op    = step_op(step_q);
    wdata = '0;
    case (step_q)
      3'd0:    wdata = {{(32 - PageW){1'b0}}, page_q};
      3'd1:    wdata = {{(32 - WdW){1'b0}}, wd_q};
      3'd2:    wdata = {31'b0, en_q};
      default: wdata = '0;
    endcase
  end

  // Read-back compare against the latched field, masked to the field width
  always_comb begin
    mismatch = 1'b0;
    case (step_q)
      3'd3:    mismatch = (rdata_q[PageW-1:0] != page_q);
      3'd4:    mismatch = (rdata_q[WdW-1:0] != wd_q);
      3'd5:    mismatch = (rdata_q[0] != en_q);
      default: mismatch = 1'b0;
    endcase
  end

  always_comb begin
    step_after_write = step_q + 3'd1;
    if (!VERIFY && (step_q == StepLastWrite)) step_after_write = StepLast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      step_q       <= '0;
      page_q       <= '0;
      wd_q         <= '0;
      en_q         <= 1'b0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= ErrOk;
      status_src   <= '0;
      av_address   <= '0;
      av_write     <= 1'b0;
      av_read      <= 1'b0;
      av_writedata <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_start) begin
            page_q  <= cmd_page_addr;
            wd_q    <= cmd_wd_value;
            en_q    <= cmd_wd_en;
            step_q  <= '0;
            busy    <= 1'b1;
            error   <= ErrOk;
            state_q <= StIssue;
          end
        end

        StIssue: begin
          if (!av_write && !av_read) begin
            // Idle slot: present the command for the current step
            av_write     <= ~op.is_read;
            av_read      <= op.is_read;
            av_address   <= {op.src, 1'b0, op.param};
            av_writedata <= op.is_read ? 32'd0 : wdata;
          end else if (!av_waitrequest) begin
            av_write     <= 1'b0;
            av_read      <= 1'b0;
            av_writedata <= '0;
            if (av_read) begin
              cnt_q   <= '0;
              state_q <= StWaitRd;
            end else begin
              step_q <= step_after_write;
            end
          end
        end

        StWaitRd: begin
          if (av_readdatavalid) begin
            rdata_q <= av_readdata[StatusW-1:0];
            state_q <= StCheck;
          end else if (cnt_q == CntLast) begin
            error   <= ErrTimeout;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StFinish;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StCheck: begin
          if (step_q == StepLast) begin
            status_src <= rdata_q;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_q    <= StFinish;
          end else if (mismatch) begin
            error   <= ErrMismatch;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StFinish;
          end else begin
            step_q  <= step_q + 3'd1;
            state_q <= StIssue;
          end
        end

        // done is high for exactly this cycle; cmd_start is not looked at here
        StFinish: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_update_avalon_master.sv
// Directed bench for remote_update_avalon_master: a verifying instance driven by an echo
// slave, and a non-verifying instance driven by a fixed-data slave.
module tb_remote_update_avalon_master;

  logic clk;
  logic rst_n;

  // Instance 1: VERIFY=1, RD_TIMEOUT=8
  logic        cmd_start1;
  logic [21:0] cmd_page1;
  logic [11:0] cmd_wd1;
  logic        cmd_en1;
  logic        busy1, done1;
  logic [1:0]  error1;
  logic [28:0] status1;
  logic [5:0]  addr1;
  logic        wr1, rd1;
  logic [31:0] wdata1;
  logic        wait1;
  logic [31:0] rdata1;
  logic        rdv1;

  // Instance 2: VERIFY=0, RD_TIMEOUT=8
  logic        cmd_start2;
  logic [21:0] cmd_page2;
  logic [11:0] cmd_wd2;
  logic        cmd_en2;
  logic        busy2, done2;
  logic [1:0]  error2;
  logic [28:0] status2;
  logic [5:0]  addr2;
  logic        wr2, rd2;
  logic [31:0] wdata2;
  logic        wait2;
  logic [31:0] rdata2;
  logic        rdv2;

  assign wait2 = 1'b0;

  remote_update_avalon_master #(.RD_TIMEOUT(8), .VERIFY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start1), .cmd_page_addr(cmd_page1), .cmd_wd_value(cmd_wd1),
    .cmd_wd_en(cmd_en1), .busy(busy1), .done(done1), .error(error1),
    .status_src(status1), .av_address(addr1), .av_write(wr1), .av_read(rd1),
    .av_writedata(wdata1), .av_waitrequest(wait1), .av_readdata(rdata1),
    .av_readdatavalid(rdv1)
  );

  remote_update_avalon_master #(.RD_TIMEOUT(8), .VERIFY(1'b0)) dut_nv (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start2), .cmd_page_addr(cmd_page2), .cmd_wd_value(cmd_wd2),
    .cmd_wd_en(cmd_en2), .busy(busy2), .done(done2), .error(error2),
    .status_src(status2), .av_address(addr2), .av_write(wr2), .av_read(rd2),
    .av_writedata(wdata2), .av_waitrequest(wait2), .av_readdata(rdata2),
    .av_readdatavalid(rdv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Echo slave for instance 1; address 0x10 is the reconfig-source register
  logic [31:0] mem [0:63];
  logic [6:0]  log1 [$];
  logic [6:0]  log2 [$];
  bit          corrupt;
  bit          no_rdv;

  always @(posedge clk) begin
    rdv1 <= 1'b0;
    if (rst_n) begin
      if (wr1 && !wait1) begin
        mem[addr1] <= wdata1;
        log1.push_back({1'b1, addr1});
      end
      if (rd1 && !wait1) begin
        log1.push_back({1'b0, addr1});
        if (!no_rdv) begin
          rdv1 <= 1'b1;
          if (addr1 == 6'h10)                 rdata1 <= 32'hE0AB_CDE1;
          else if (corrupt && addr1 == 6'h04) rdata1 <= 32'h0001_2344;
          else                                rdata1 <= mem[addr1];
        end
      end
    end
  end

  always @(posedge clk) begin
    rdv2 <= 1'b0;
    if (rst_n) begin
      if (wr2) log2.push_back({1'b1, addr2});
      if (rd2) begin
        log2.push_back({1'b0, addr2});
        rdv2   <= 1'b1;
        rdata2 <= 32'h1555_5555;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start1(input logic [21:0] page, input logic [11:0] wd, input logic en);
    @(negedge clk);
    cmd_page1  = page;
    cmd_wd1    = wd;
    cmd_en1    = en;
    cmd_start1 = 1'b1;
    @(negedge clk);
    cmd_start1 = 1'b0;
  endtask

  task automatic start2(input logic [21:0] page, input logic [11:0] wd, input logic en);
    @(negedge clk);
    cmd_page2  = page;
    cmd_wd2    = wd;
    cmd_en2    = en;
    cmd_start2 = 1'b1;
    @(negedge clk);
    cmd_start2 = 1'b0;
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done2();
    int n = 0;
    while (!done2 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_read_accept1();
    int n = 0;
    while (!(rd1 && !wait1) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [6:0] log1_at(input int i);
    return (i < log1.size()) ? log1[i] : 7'h7f;
  endfunction

  function automatic logic [6:0] log2_at(input int i);
    return (i < log2.size()) ? log2[i] : 7'h7f;
  endfunction

  logic [6:0] exp_full [7];
  logic [6:0] exp_nv   [4];
  int         k;
  int         n_w4;

  initial begin
    exp_full = '{7'h44, 7'h42, 7'h43, 7'h04, 7'h02, 7'h03, 7'h10};
    exp_nv   = '{7'h44, 7'h42, 7'h43, 7'h10};
    rst_n = 1'b0;
    cmd_start1 = 1'b0; cmd_page1 = '0; cmd_wd1 = '0; cmd_en1 = 1'b0;
    cmd_start2 = 1'b0; cmd_page2 = '0; cmd_wd2 = '0; cmd_en2 = 1'b0;
    wait1 = 1'b0; corrupt = 1'b0; no_rdv = 1'b0;
    #1;
    check("rst_state", {busy1, done1, error1, wr1, rd1, addr1, wdata1, status1}, '0);
    check("rst_state_nv", {busy2, done2, error2, wr2, rd2, addr2, wdata2, status2}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Full sequence with echoing slave
    log1.delete();
    start1(22'h12345, 12'h0FF, 1'b1);
    check("busy_after_start", busy1, 1'b1);
    wait_done1();
    check("a_done", done1, 1'b1);
    check("a_busy_with_done", busy1, 1'b0);
    check("a_error", error1, 2'd0);
    check("a_status", status1, 29'h00AB_CDE1);
    check("a_ops", log1.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("a_op%0d", i), log1_at(i), exp_full[i]);
    check("a_wr_page", mem[4], 32'h0001_2345);
    check("a_wr_wd", mem[2], 32'h0000_00FF);
    check("a_wr_en", mem[3], 32'h0000_0001);
    @(negedge clk);
    check("a_done_pulse", done1, 1'b0);

    // Stalled first write must hold command, address and data
    log1.delete();
    wait1 = 1'b1;
    start1(22'h2A5A5, 12'h123, 1'b0);
    k = 0;
    while (!wr1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b_stall0", {wr1, rd1, addr1, wdata1}, {1'b1, 1'b0, 6'h04, 32'h0002_A5A5});
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b_stall%0d", i), {wr1, rd1, addr1, wdata1},
            {1'b1, 1'b0, 6'h04, 32'h0002_A5A5});
    end
    wait1 = 1'b0;
    wait_done1();
    check("b_done", done1, 1'b1);
    check("b_error", error1, 2'd0);
    n_w4 = 0;
    foreach (log1[i]) if (log1[i] == 7'h44) n_w4++;
    check("b_single_write", n_w4, 1);
    check("b_ops", log1.size(), 7);

    // Read-back mismatch on page aborts after step 3
    log1.delete();
    corrupt = 1'b1;
    start1(22'h12345, 12'h0FF, 1'b1);
    wait_done1();
    check("c_done", done1, 1'b1);
    check("c_error", error1, 2'd1);
    check("c_ops", log1.size(), 4);
    check("c_last_op", log1_at(3), 7'h04);
    corrupt = 1'b0;

    // Read timeout: done exactly 8 cycles after the read is accepted
    log1.delete();
    no_rdv = 1'b1;
    start1(22'h00001, 12'h001, 1'b1);
    wait_read_accept1();
    check("d_read_seen", rd1 && !wait1, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done1 && k < 40);
    check("d_timeout_latency", k - 1, 8);
    check("d_error", error1, 2'd2);
    cmd_start1 = 1'b1;  // coincides with done, must be dropped
    @(negedge clk);
    cmd_start1 = 1'b0;
    check("d_start_ignored", busy1, 1'b0);
    @(negedge clk);
    check("d_still_idle", {busy1, wr1, rd1}, 3'b000);

    // Reset during WAIT_RD abandons the sequence
    log1.delete();
    start1(22'h0ABCD, 12'h456, 1'b1);
    wait_read_accept1();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("e_rst_outputs", {busy1, done1, error1, wr1, rd1, addr1, wdata1, status1}, '0);
    @(negedge clk);
    check("e_no_done", done1, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    no_rdv = 1'b0;
    @(negedge clk);
    check("e_idle_after_release", {busy1, done1, wr1, rd1}, 4'b0000);
    log1.delete();
    start1(22'h0ABCD, 12'h456, 1'b1);
    wait_done1();
    check("e_done", done1, 1'b1);
    check("e_error", error1, 2'd0);
    check("e_status", status1, 29'h00AB_CDE1);
    check("e_ops", log1.size(), 7);

    // VERIFY=0: three writes then the reconfig-source read
    log2.delete();
    start2(22'h3FFFFF, 12'hFFF, 1'b1);
    wait_done2();
    check("f_done", done2, 1'b1);
    check("f_error", error2, 2'd0);
    check("f_status", status2, 29'h1555_5555);
    check("f_ops", log2.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("f_op%0d", i), log2_at(i), exp_nv[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/remote_update_avalon_master.md
REMOTE_UPDATE_AVALON_MASTER -- requirements
Module: remote_update_avalon_master

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 255, meaning max cycles from read acceptance to av_readdatavalid before error.
REQ-002 SHALL have parameter VERIFY, default 1, meaning 1 enables read-back compare of each written field, 0 skips read-back.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd_start  input  1  one-cycle pulse requesting a programming sequence; ignored while busy.
REQ-006 cmd_page_addr  input  22  boot page address, sampled on accepted cmd_start.
REQ-007 cmd_wd_value  input  12  watchdog timeout value, sampled on accepted cmd_start.
REQ-008 cmd_wd_en  input  1  watchdog enable, sampled on accepted cmd_start.
REQ-009 busy  output  1  high from the cycle after an accepted cmd_start until done pulses.
REQ-010 done  output  1  one-cycle pulse at sequence end.
REQ-011 error  output  2  status valid with done: 0 ok, 1 readback mismatch, 2 read timeout.
REQ-012 status_src  output  29  last readdata of reconfig-source read, valid with done.
REQ-013 av_address  output  6  [5:4] source, [3] zero, [2:0] param.
REQ-014 av_write, av_read  output  1 each  Avalon-MM master commands; never both high.
REQ-015 av_writedata  output  32  write data, field in LSBs, rest zero.
REQ-016 av_waitrequest  input  1  slave stall.
REQ-017 av_readdata  input  32  read data; only [28:0] used.
REQ-018 av_readdatavalid  input  1  read data strobe.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_RD, CHECK, FINISH; a step index (0-6) SHALL select the current operation.
REQ-020 Step table SHALL be: 0 WR param 100 src 00 page; 1 WR param 010 src 00 wd_value; 2 WR param 011 src 00 wd_en; 3 RD 100; 4 RD 010; 5 RD 011; 6 RD param 000 src 01 (reconfig source).
REQ-021 VERIFY=0 SHALL skip steps 3-5 (step 2 proceeds to step 6).
REQ-022 IDLE + cmd_start SHALL latch cmd_* inputs, set step 0, enter ISSUE next cycle.
REQ-023 In ISSUE the command, address and data SHALL be held constant while av_waitrequest is high; command accepted on first cycle with av_waitrequest low.
REQ-024 Accepted write SHALL advance step and remain in ISSUE (next command on next cycle, commands deasserted for exactly one cycle between operations).
REQ-025 Accepted read SHALL enter WAIT_RD with av_read deasserted the next cycle and timeout counter cleared.
REQ-026 WAIT_RD SHALL capture av_readdata on av_readdatavalid and enter CHECK; counter reaching RD_TIMEOUT first SHALL set error=2 and enter FINISH.
REQ-027 CHECK SHALL compare readdata masked to field width (22/12/1 bits) with latched value; mismatch sets error=1, enters FINISH; step 6 stores status_src, enters FINISH.
REQ-028 First error SHALL abort remaining steps.
REQ-029 FINISH SHALL pulse done for one cycle, return to IDLE; busy low in that same cycle as done.
REQ-030 av_readdatavalid outside WAIT_RD SHALL be ignored.
REQ-031 cmd_start coincident with done SHALL be ignored.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, step 0, av_read=av_write=0, av_address=0, av_writedata=0, busy=0, done=0, error=0, status_src=0.
REQ-033 Reset mid-sequence SHALL abandon the operation without done; first cycle after release is IDLE.

Structure
REQ-034 Param codes (000,010,011,100), source codes (00,01), error codes and state encodings SHALL live in shared package remote_update_pkg.
REQ-035 Single module; no sub-module required.

Verification
REQ-036 page=0x12345, wd=0x0FF, en=1, slave echoes, waitrequest 0 -> 7 operations in order, done with error=0, status_src = slave value.
REQ-037 waitrequest high 5 cycles on step 0 -> av_write/address/data stable all 5 cycles, single write accepted.
REQ-038 slave returns page 0x12344 on step 3 -> done error=1, step 4-6 never issued.
REQ-039 RD_TIMEOUT=8, no readdatavalid -> done error=2 exactly 8 cycles after read accepted.
REQ-040 VERIFY=0 -> 3 writes then one read of src 01 param 000; done error=0.
REQ-041 rst_n low during WAIT_RD -> all outputs 0 immediately, no done; new cmd_start after release runs full sequence.
